// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, completion status encoding, master
// FSM state encoding and the even-parity helper used by AD/CBE parity logic.
package pci_pkg;

    // Bus commands driven on C/BE# during the address phase.
    localparam logic [3:0] CMD_IO_READ  = 4'b0010;
    localparam logic [3:0] CMD_IO_WRITE = 4'b0011;

    // Completion status reported on rsp_status.
    localparam logic [1:0] STS_OK        = 2'b00;
    localparam logic [1:0] STS_MABORT    = 2'b01;
    localparam logic [1:0] STS_TABORT    = 2'b10;
    localparam logic [1:0] STS_RETRY_LIM = 2'b11;

    // Master FSM state encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_TURN = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // Even parity: PAR makes the total count of ones over AD, CBE and PAR even.
    function automatic logic pci_parity(input logic [31:0] ad, input logic [3:0] cbe);
        return ^{ad, cbe};
    endfunction

endpackage

// File: rtl/pci_par_gen.sv
// Registered PAR generation. PAR (and its output enable) trail the AD/CBE
// values they cover by exactly one clock, as the PCI protocol requires.
module pci_par_gen
    import pci_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] ad_i,
    input  logic [3:0]  cbe_i,
    input  logic        drive_i,
    output logic        par_o,
    output logic        par_oe_o
);

    logic par_d;
    logic par_q;
    logic par_oe_q;

    assign par_d = pci_parity(ad_i, cbe_i);

    // Capture parity of this cycle's AD/CBE and whether AD was driven.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q    <= 1'b0;
            par_oe_q <= 1'b0;
        end else begin
            par_q    <= par_d;
            par_oe_q <= drive_i;
        end
    end

    assign par_o    = par_q;
    assign par_oe_o = par_oe_q;

endmodule

// File: rtl/pci_io_master.sv
// Single-data-phase PCI IO master. Takes one local request at a time,
// arbitrates for the bus, runs an IORead/IOWrite and reports a status.
//
// Local handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so exactly one
// transfer is outstanding. The completion is a single-cycle rsp_valid pulse
// with no back-pressure; rsp_rdata/rsp_status stay stable until the next one.
module pci_io_master
    import pci_pkg::*;
#(
    parameter int DEVSEL_TIMEOUT = 4,
    parameter int RETRY_LIMIT    = 16
) (
    input  logic        PCI_CLK,
    input  logic        PCI_RSTn,
    output logic        PCI_REQn,
    input  logic        PCI_GNTn,
    inout  logic        PCI_FRAMEn,
    inout  logic        PCI_IRDYn,
    inout  logic [31:0] PCI_AD,
    inout  logic [3:0]  PCI_CBE,
    inout  logic        PCI_PAR,
    input  logic        PCI_TRDYn,
    input  logic        PCI_DEVSELn,
    input  logic        PCI_STOPn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic [2:0]  dbg_state_o
);

    localparam logic [7:0] DEV_LAST   = 8'(DEVSEL_TIMEOUT - 1);
    localparam logic [7:0] RETRY_LAST = 8'(RETRY_LIMIT);

    logic [2:0]  state_q,       state_d;
    logic        write_q,       write_d;
    logic [31:0] addr_q,        addr_d;
    logic [31:0] wdata_q,       wdata_d;
    logic [3:0]  be_q,          be_d;
    logic [7:0]  retry_q,       retry_d;
    logic [7:0]  dev_cnt_q,     dev_cnt_d;
    logic        again_q,       again_d;
    logic [1:0]  pend_status_q, pend_status_d;
    logic [31:0] pend_rdata_q,  pend_rdata_d;
    logic [1:0]  rsp_status_q,  rsp_status_d;
    logic [31:0] rsp_rdata_q,   rsp_rdata_d;

    logic        frame_oe, frame_out;
    logic        irdy_oe,  irdy_out;
    logic        ad_oe;
    logic [31:0] ad_out;
    logic        cbe_oe;
    logic [3:0]  cbe_out;
    logic        par_out, par_oe;

    // Next-state logic: arbitration, phase sequencing and completion decode.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        retry_d       = retry_q;
        dev_cnt_d     = dev_cnt_q;
        again_d       = again_q;
        pend_status_d = pend_status_q;
        pend_rdata_d  = pend_rdata_q;
        rsp_status_d  = rsp_status_q;
        rsp_rdata_d   = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    retry_d = 8'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Grant alone is not enough: the previous owner must have
                // finished (FRAME# and IRDY# both idle) in the same sample.
                if (!PCI_GNTn && PCI_FRAMEn && PCI_IRDYn) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                dev_cnt_d = 8'd0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (dev_cnt_q != DEV_LAST) begin
                    dev_cnt_d = dev_cnt_q + 8'd1;
                end
                if (!PCI_IRDYn && !PCI_TRDYn) begin
                    pend_status_d = STS_OK;
                    pend_rdata_d  = write_q ? 32'h0 : PCI_AD;
                    again_d       = 1'b0;
                    state_d       = ST_TURN;
                end else if (!PCI_STOPn && PCI_DEVSELn) begin
                    pend_status_d = STS_TABORT;
                    pend_rdata_d  = 32'h0;
                    again_d       = 1'b0;
                    state_d       = ST_TURN;
                end else if (!PCI_STOPn && !PCI_DEVSELn) begin
                    // Retry: go round arbitration again unless the limit is hit.
                    retry_d = retry_q + 8'd1;
                    state_d = ST_TURN;
                    if (retry_q + 8'd1 == RETRY_LAST) begin
                        pend_status_d = STS_RETRY_LIM;
                        pend_rdata_d  = 32'h0;
                        again_d       = 1'b0;
                    end else begin
                        again_d = 1'b1;
                    end
                end else if (PCI_DEVSELn && dev_cnt_q == DEV_LAST) begin
                    pend_status_d = STS_MABORT;
                    pend_rdata_d  = 32'hFFFF_FFFF;
                    again_d       = 1'b0;
                    state_d       = ST_TURN;
                end
            end
            ST_TURN: begin
                if (again_q) begin
                    state_d = ST_REQ;
                end else begin
                    rsp_status_d = pend_status_q;
                    rsp_rdata_d  = pend_rdata_q;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transfer registers; reset abandons any transfer silently.
    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            be_q          <= 4'h0;
            retry_q       <= 8'd0;
            dev_cnt_q     <= 8'd0;
            again_q       <= 1'b0;
            pend_status_q <= STS_OK;
            pend_rdata_q  <= 32'h0;
            rsp_status_q  <= STS_OK;
            rsp_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            retry_q       <= retry_d;
            dev_cnt_q     <= dev_cnt_d;
            again_q       <= again_d;
            pend_status_q <= pend_status_d;
            pend_rdata_q  <= pend_rdata_d;
            rsp_status_q  <= rsp_status_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    // Shared-bus drive decode; everything floats outside ADDR/DATA/TURN.
    always_comb begin
        frame_oe  = 1'b0;
        frame_out = 1'b1;
        irdy_oe   = 1'b0;
        irdy_out  = 1'b1;
        ad_oe     = 1'b0;
        ad_out    = addr_q;
        cbe_oe    = 1'b0;
        cbe_out   = write_q ? CMD_IO_WRITE : CMD_IO_READ;
        case (state_q)
            ST_ADDR: begin
                frame_oe  = 1'b1;
                frame_out = 1'b0;
                irdy_oe   = 1'b1;
                ad_oe     = 1'b1;
                cbe_oe    = 1'b1;
            end
            ST_DATA: begin
                // Single data phase, so FRAME# is already deasserted here.
                frame_oe = 1'b1;
                irdy_oe  = 1'b1;
                irdy_out = 1'b0;
                ad_oe    = write_q;
                ad_out   = wdata_q;
                cbe_oe   = 1'b1;
                cbe_out  = ~be_q;
            end
            ST_TURN: begin
                // Park FRAME#/IRDY# high for a cycle before letting go.
                frame_oe = 1'b1;
                irdy_oe  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    pci_par_gen u_par_gen (
        .clk_i    (PCI_CLK),
        .rst_ni   (PCI_RSTn),
        .ad_i     (ad_out),
        .cbe_i    (cbe_out),
        .drive_i  (ad_oe),
        .par_o    (par_out),
        .par_oe_o (par_oe)
    );

    assign PCI_FRAMEn = frame_oe ? frame_out : 1'bz;
    assign PCI_IRDYn  = irdy_oe  ? irdy_out  : 1'bz;
    assign PCI_AD     = ad_oe    ? ad_out    : 32'hzzzz_zzzz;
    assign PCI_CBE    = cbe_oe   ? cbe_out   : 4'hz;
    assign PCI_PAR    = par_oe   ? par_out   : 1'bz;

    assign PCI_REQn    = (state_q != ST_REQ);
    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_status  = rsp_status_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pci_io_master.sv
// Directed bench for pci_io_master. Bus release is observed by briefly
// driving a 0 onto a shared line: it reads back 0 only if the DUT lets go.
module tb_pci_io_master;
    import pci_pkg::*;

    // ---------------- clock / reset ----------------
    logic PCI_CLK = 1'b0;
    logic PCI_RSTn;
    always #5 PCI_CLK = ~PCI_CLK;

    logic        PCI_GNTn, PCI_TRDYn, PCI_DEVSELn, PCI_STOPn;
    logic        PCI_REQn;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [2:0]  dbg_state;

    wire         PCI_FRAMEn, PCI_IRDYn, PCI_PAR;
    wire  [31:0] PCI_AD;
    wire  [3:0]  PCI_CBE;

    pullup pu_frame (PCI_FRAMEn);
    pullup pu_irdy  (PCI_IRDYn);

    logic        probe_ctl = 1'b0, probe_ad = 1'b0, probe_cbe = 1'b0, probe_par = 1'b0;
    logic        tgt_ad_oe = 1'b0;
    logic [31:0] tgt_ad    = 32'h0;

    assign PCI_FRAMEn = probe_ctl ? 1'b0 : 1'bz;
    assign PCI_IRDYn  = probe_ctl ? 1'b0 : 1'bz;
    assign PCI_AD     = probe_ad ? 32'h0 : (tgt_ad_oe ? tgt_ad : 32'hzzzz_zzzz);
    assign PCI_CBE    = probe_cbe ? 4'h0 : 4'hz;
    assign PCI_PAR    = probe_par ? 1'b0 : 1'bz;

    pci_io_master #(.DEVSEL_TIMEOUT(4), .RETRY_LIMIT(16)) dut (
        .PCI_CLK     (PCI_CLK),
        .PCI_RSTn    (PCI_RSTn),
        .PCI_REQn    (PCI_REQn),
        .PCI_GNTn    (PCI_GNTn),
        .PCI_FRAMEn  (PCI_FRAMEn),
        .PCI_IRDYn   (PCI_IRDYn),
        .PCI_AD      (PCI_AD),
        .PCI_CBE     (PCI_CBE),
        .PCI_PAR     (PCI_PAR),
        .PCI_TRDYn   (PCI_TRDYn),
        .PCI_DEVSELn (PCI_DEVSELn),
        .PCI_STOPn   (PCI_STOPn),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_status  (rsp_status),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks  = 0;
    int errors  = 0;
    int rsp_cnt = 0;
    int addr_cnt;
    logic [33:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every completion pulse must match the oldest expected response.
    always @(negedge PCI_CLK) begin
        if (rsp_valid) begin
            logic [33:0] e;
            rsp_cnt++;
            chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_rsp", 64'({rsp_status, rsp_rdata}), 64'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge PCI_CLK);
        #1;
    endtask

    // m = {frame/irdy, ad, cbe, par}: selected lines must be released.
    task automatic released(input string tag, input logic [3:0] m);
        logic [38:0] obs;
        probe_ctl = m[3];
        probe_ad  = m[2];
        probe_cbe = m[1];
        probe_par = m[0];
        #1;
        obs = {PCI_FRAMEn & m[3], PCI_IRDYn & m[3], PCI_AD & {32{m[2]}},
               PCI_CBE & {4{m[1]}}, PCI_PAR & m[0]};
        chk(tag, 64'(obs), 64'd0);
        probe_ctl = 1'b0;
        probe_ad  = 1'b0;
        probe_cbe = 1'b0;
        probe_par = 1'b0;
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        cyc();
        req_valid = 1'b0;
        chk("req_state", 64'(dbg_state), 64'(ST_REQ));
        chk("req_reqn", 64'(PCI_REQn), 64'd0);
        chk("req_ready_low", 64'(req_ready), 64'd0);
    endtask

    // One grant cycle, then check the address phase (cycle N).
    task automatic grant_addr(input logic [31:0] a, input logic [3:0] cmd);
        PCI_GNTn = 1'b0;
        cyc();
        PCI_GNTn = 1'b1;
        if (PCI_FRAMEn === 1'b0) addr_cnt++;
        chk("addr_frame", 64'(PCI_FRAMEn), 64'd0);
        chk("addr_ad", 64'(PCI_AD), 64'(a));
        chk("addr_cbe", 64'(PCI_CBE), 64'(cmd));
        chk("addr_reqn", 64'(PCI_REQn), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        PCI_RSTn    = 1'b0;
        PCI_GNTn    = 1'b1;
        PCI_TRDYn   = 1'b1;
        PCI_DEVSELn = 1'b1;
        PCI_STOPn   = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_be      = 4'h0;
        addr_cnt    = 0;
        cyc();
        cyc();
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_reqn", 64'(PCI_REQn), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp", 64'({rsp_status, rsp_rdata}), 64'd0);
        released("rst_bus", 4'b1111);
        PCI_RSTn = 1'b1;
        cyc();

        // IO write 0x204 <- A5A5A5A5, target DEVSEL/TRDY at N+2.
        exp_q.push_back({STS_OK, 32'h0});
        issue(1'b1, 32'h0000_0204, 32'hA5A5_A5A5, 4'hF);
        cyc();
        cyc();
        chk("wr_hold_req", 64'(dbg_state), 64'(ST_REQ));
        grant_addr(32'h0000_0204, 4'b0011);
        cyc();
        chk("wr_n1_state", 64'(dbg_state), 64'(ST_DATA));
        chk("wr_n1_ctl", 64'({PCI_FRAMEn, PCI_IRDYn}), 64'b10);
        chk("wr_n1_ad", 64'(PCI_AD), 64'hA5A5_A5A5);
        chk("wr_n1_cbe", 64'(PCI_CBE), 64'h0);
        chk("wr_n1_par", 64'(PCI_PAR), 64'd0);
        cyc();
        chk("wr_n2_ad", 64'(PCI_AD), 64'hA5A5_A5A5);
        chk("wr_n2_par", 64'(PCI_PAR), 64'd0);
        PCI_DEVSELn = 1'b0;
        PCI_TRDYn   = 1'b0;
        cyc();
        PCI_DEVSELn = 1'b1;
        PCI_TRDYn   = 1'b1;
        chk("wr_n3_state", 64'(dbg_state), 64'(ST_TURN));
        chk("wr_n3_ctl", 64'({PCI_FRAMEn, PCI_IRDYn}), 64'b11);
        chk("wr_n3_par", 64'(PCI_PAR), 64'd0);
        released("wr_n3_adcbe", 4'b0110);
        cyc();
        chk("wr_done", 64'({rsp_valid, rsp_status}), 64'b100);
        released("wr_done_bus", 4'b1111);
        cyc();
        chk("wr_idle", 64'({rsp_valid, req_ready, rsp_status}), 64'b0100);

        // IO read 0x208, be 0101, DEVSEL at N+2, data at N+3.
        exp_q.push_back({STS_OK, 32'h1234_5678});
        issue(1'b0, 32'h0000_0208, 32'h0, 4'b0101);
        grant_addr(32'h0000_0208, 4'b0010);
        cyc();
        chk("rd_n1_irdy", 64'(PCI_IRDYn), 64'd0);
        chk("rd_n1_cbe", 64'(PCI_CBE), 64'b1010);
        chk("rd_n1_par", 64'(PCI_PAR), 64'd1);
        released("rd_n1_ad", 4'b0100);
        cyc();
        released("rd_n2_par", 4'b0001);
        PCI_DEVSELn = 1'b0;
        cyc();
        chk("rd_n3_state", 64'(dbg_state), 64'(ST_DATA));
        PCI_TRDYn = 1'b0;
        tgt_ad    = 32'h1234_5678;
        tgt_ad_oe = 1'b1;
        cyc();
        PCI_TRDYn   = 1'b1;
        PCI_DEVSELn = 1'b1;
        tgt_ad_oe   = 1'b0;
        chk("rd_turn", 64'({dbg_state, PCI_IRDYn}), 64'({ST_TURN, 1'b1}));
        cyc();
        chk("rd_done", 64'({rsp_valid, rsp_status, rsp_rdata}), 64'({1'b1, STS_OK, 32'h1234_5678}));
        cyc();

        // No target: master abort after 4 DATA cycles.
        exp_q.push_back({STS_MABORT, 32'hFFFF_FFFF});
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        grant_addr(32'h0000_0300, 4'b0010);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("ma_data", 64'({dbg_state, PCI_IRDYn}), 64'({ST_DATA, 1'b0}));
        end
        cyc();
        chk("ma_turn", 64'({dbg_state, PCI_FRAMEn, PCI_IRDYn}), 64'({ST_TURN, 2'b11}));
        cyc();
        chk("ma_done", 64'({rsp_valid, rsp_status, rsp_rdata}), 64'({1'b1, STS_MABORT, 32'hFFFF_FFFF}));
        released("ma_irdy_z", 4'b1000);
        cyc();

        // Target abort on a partial-byte write.
        exp_q.push_back({STS_TABORT, 32'h0});
        issue(1'b1, 32'h0000_0400, 32'h0000_0001, 4'b0011);
        grant_addr(32'h0000_0400, 4'b0011);
        cyc();
        chk("ta_n1", 64'({PCI_AD, PCI_CBE}), 64'({32'h0000_0001, 4'b1100}));
        PCI_STOPn   = 1'b0;
        PCI_DEVSELn = 1'b1;
        cyc();
        PCI_STOPn = 1'b1;
        chk("ta_turn", 64'({dbg_state, PCI_IRDYn}), 64'({ST_TURN, 1'b1}));
        cyc();
        chk("ta_done", 64'({rsp_valid, rsp_status, rsp_rdata}), 64'({1'b1, STS_TABORT, 32'h0}));
        cyc();

        // Grant withdrawn while the bus is busy, then 16 retries.
        exp_q.push_back({STS_RETRY_LIM, 32'h0});
        issue(1'b1, 32'h0000_0500, 32'hCAFE_F00D, 4'hF);
        probe_ctl = 1'b1;
        PCI_GNTn  = 1'b0;
        cyc();
        cyc();
        PCI_GNTn = 1'b1;
        cyc();
        probe_ctl = 1'b0;
        cyc();
        chk("gnt_wd_state", 64'({dbg_state, PCI_REQn}), 64'({ST_REQ, 1'b0}));
        chk("gnt_wd_frame", 64'(PCI_FRAMEn), 64'd1);
        addr_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            grant_addr(32'h0000_0500, 4'b0011);
            cyc();
            PCI_STOPn   = 1'b0;
            PCI_DEVSELn = 1'b0;
            cyc();
            PCI_STOPn   = 1'b1;
            PCI_DEVSELn = 1'b1;
            chk("rt_turn", 64'({dbg_state, PCI_IRDYn}), 64'({ST_TURN, 1'b1}));
            cyc();
            if (k < 15) begin
                chk("rt_rearb", 64'({dbg_state, PCI_REQn, rsp_valid}), 64'({ST_REQ, 2'b00}));
            end else begin
                chk("rt_done", 64'({rsp_valid, rsp_status}), 64'({1'b1, STS_RETRY_LIM}));
            end
        end
        chk("rt_addr_phases", 64'(addr_cnt), 64'd16);
        cyc();

        // Reset asserted during DATA.
        issue(1'b1, 32'h0000_0600, 32'h0000_1234, 4'hF);
        grant_addr(32'h0000_0600, 4'b0011);
        cyc();
        chk("rs_in_data", 64'(dbg_state), 64'(ST_DATA));
        #2;
        PCI_RSTn = 1'b0;
        #1;
        chk("rs_async", 64'({dbg_state, PCI_REQn, rsp_valid, req_ready}), 64'({ST_IDLE, 3'b101}));
        chk("rs_rsp_clr", 64'({rsp_status, rsp_rdata}), 64'd0);
        released("rs_bus", 4'b1111);
        cyc();
        PCI_RSTn = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("rsp_pulses", 64'(rsp_cnt), 64'd5);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_io_master.md
PCI_IO_MASTER -- requirements
Module: pci_io_master

Interface
REQ-001 Parameters SHALL be:
- DEVSEL_TIMEOUT, 4, clocks after the address phase in which DEVSEL# is sampled before master abort.
- RETRY_LIMIT, 16, retries before a transfer is reported failed.
REQ-002 PCI_CLK  in  1  PCI clock; all logic on its rising edge.
REQ-003 PCI_RSTn  in  1  reset; asynchronous, active-low.
REQ-004 PCI_REQn  out  1  bus request, active-low.
REQ-005 PCI_GNTn  in  1  bus grant, active-low.
REQ-006 PCI_FRAMEn  inout  1  frame; driven only while this master owns the bus.
REQ-007 PCI_IRDYn  inout  1  initiator ready; same ownership rule as PCI_FRAMEn.
REQ-008 PCI_AD  inout  32  address/data bus.
REQ-009 PCI_CBE  inout  4  command/byte-enables, active-low byte enables.
REQ-010 PCI_PAR  inout  1  even parity over PCI_AD and PCI_CBE.
REQ-011 PCI_TRDYn, PCI_DEVSELn, PCI_STOPn  in  1 each  target responses.
REQ-012 req_valid  in  1  local transfer request; req_write  in  1  1=IO write, 0=IO read.
REQ-013 req_addr  in  32; req_wdata  in  32; req_be  in  4  byte enables, active-high.
REQ-014 req_ready  out  1  high in IDLE; request accepted when req_valid & req_ready.
REQ-015 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32; rsp_status  out  2:
- 00 OK
- 01 master abort
- 10 target abort
- 11 retry limit hit

Function
REQ-016 Accepted request fields SHALL be latched. Only one transfer SHALL be outstanding, single data phase, commands IORead 0010 / IOWrite 0011.
REQ-017 States SHALL be IDLE, REQ, ADDR, DATA, TURN, DONE.
REQ-018 IDLE->REQ on acceptance; PCI_REQn SHALL go low in REQ.
REQ-019 REQ->ADDR when PCI_GNTn=0, PCI_FRAMEn=1 and PCI_IRDYn=1 are sampled together; otherwise remain in REQ.
REQ-020 ADDR, cycle N: FRAMEn=0, AD=latched addr, CBE=command, REQn=1.
REQ-021 DATA from N+1: FRAMEn=1, IRDYn=0, CBE=~be. On writes AD=wdata; on reads AD is released (turnaround).
REQ-022 PAR SHALL be driven in the cycle after each cycle in which this block drives AD: the address phase, and write data cycles. PAR SHALL be released otherwise.
REQ-023 In DATA, on sampling IRDYn=0 & TRDYn=0: reads SHALL capture AD into rsp_rdata; status 00; go to TURN.
REQ-024 In DATA, STOPn=0 & TRDYn=1 & DEVSELn=0 (retry) SHALL increment the retry count. Next is TURN then REQ, or TURN then DONE with status 11 once the count reaches RETRY_LIMIT.
REQ-025 In DATA, STOPn=0 & DEVSELn=1 (target abort) SHALL give status 10, then TURN.
REQ-026 DEVSELn still 1 after DEVSEL_TIMEOUT DATA cycles SHALL give a master abort: status 01, rsp_rdata=FFFFFFFF, then TURN.
REQ-027 TURN SHALL drive IRDYn=1 (FRAMEn=1) for one cycle and release AD/CBE. The next cycle SHALL release all shared signals.
REQ-028 DONE SHALL pulse rsp_valid for one cycle and return to IDLE. rsp_rdata and rsp_status SHALL hold until the next completion.
REQ-029 The retry count SHALL clear on each new acceptance.
REQ-030 GNTn deasserted before the address phase SHALL keep the block in REQ. GNTn changes after ADDR SHALL be ignored.

Reset
REQ-031 PCI_RSTn low SHALL asynchronously force:
- IDLE, PCI_REQn=1, all shared PCI signals Z
- req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_status=00, retry count 0
REQ-032 Reset mid-transfer SHALL abandon the transfer without a response pulse.

Structure
REQ-033 Command codes, the status encoding and the state enumeration SHALL live in shared package pci_pkg, together with the target-side designs.
REQ-034 Registered parity generation SHALL be a sub-module pci_par_gen (inputs AD, CBE, drive-enable; outputs PAR, PAR output-enable).

Verification
REQ-035 IO write addr 00000204, data A5A5A5A5, be F, with the target giving DEVSEL/TRDY at N+2 -> AD=A5A5A5A5 and CBE=0 in data cycles; status 00; PAR correct at N+1 and N+3.
REQ-036 IO read addr 00000208, target returns 12345678 at N+3 -> rsp_rdata=12345678, status 00, AD released from N+1.
REQ-037 No target response -> master abort after 4 DATA cycles, status 01, rsp_rdata=FFFFFFFF, IRDYn driven 1 for one cycle and then Z.
REQ-038 Target retries 16 times -> 16 REQ/GNT re-arbitrations, then status 11.
REQ-039 Target abort (STOPn=0, DEVSELn=1) -> status 10. A GNTn withdrawn before ADDR -> no FRAMEn assertion.
REQ-040 PCI_RSTn asserted during DATA -> all shared signals Z in the same cycle, REQn=1, no rsp_valid.
